// File: rtl/gs_ddram_pkg.sv
// Shared types and constants for the General Sound to DDRAM bridge.
package gs_ddram_pkg;

    typedef enum logic [2:0] {IDLE, HIT, RD, RDW, WR} gs_state_t;

    localparam int          LINE_W      = 64;
    localparam int          BE_W        = 8;
    localparam logic [28:0] GS_DDR_BASE = 29'h0600000;

    // Byte lane within a 64-bit word to its one-hot byte enable.
    function automatic logic [BE_W-1:0] lane_be(input logic [2:0] lane);
        logic [BE_W-1:0] be;
        be       = '0;
        be[lane] = 1'b1;
        return be;
    endfunction

endpackage

// File: rtl/gs_line_cache.sv
// Single 64-bit line read cache: tag/valid lookup, whole-line fill and
// single-byte patch so writes keep the cached copy coherent.
module gs_line_cache
    import gs_ddram_pkg::*;
#(
    parameter int TAG_W = 18
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [LINE_W-1:0] line,
    input  logic              fill,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              patch,
    input  logic [2:0]        patch_lane,
    input  logic [7:0]        patch_byte
);

    logic [TAG_W-1:0] tag;
    logic             valid;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            line  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            line  <= fill_line;
        end else if (patch) begin
            line[{patch_lane, 3'b000} +: 8] <= patch_byte;
        end
    end

    assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/gs_ddram_bridge.sv
// General Sound 8-bit memory port onto the 64-bit DDRAM Avalon interface.
// Optional single-line read cache enabled by defining GS_BRIDGE_CACHE_EN.
module gs_ddram_bridge
    import gs_ddram_pkg::*;
#(
    parameter int          ADDR_W   = 21,
    parameter logic [28:0] DDR_BASE = GS_DDR_BASE
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              rd,
    input  logic              we,
    output logic              ready,
    input  logic              DDRAM_BUSY,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic [28:0]       DDRAM_ADDR,
    input  logic [LINE_W-1:0] DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY,
    output logic              DDRAM_RD,
    output logic [LINE_W-1:0] DDRAM_DIN,
    output logic [BE_W-1:0]   DDRAM_BE,
    output logic              DDRAM_WE
);

    localparam int TAG_W = ADDR_W - 3;

    gs_state_t         state, state_nx;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ready_r;
    logic              drain;
    logic [2:0]        lane_q;
    logic              new_req, start;
    logic              cache_hit;
    logic [LINE_W-1:0] cache_line;

    // Edge/addr-change history only advances while a request can be taken,
    // so a strobe raised during a drain is still seen once the drain ends.
    assign new_req = (rd | we) && (!req_q || (addr != addr_q));
    assign start   = (state == IDLE) && !drain && new_req;

`ifdef GS_BRIDGE_CACHE_EN
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk_sys) begin
        if (reset)
            tag_q <= '0;
        else if (start)
            tag_q <= addr[ADDR_W-1:3];
    end

    gs_line_cache #(.TAG_W(TAG_W)) u_cache (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .lookup_tag ((state == IDLE) ? addr[ADDR_W-1:3] : tag_q),
        .hit        (cache_hit),
        .line       (cache_line),
        .fill       ((state == RDW) && DDRAM_DOUT_READY),
        .fill_tag   (tag_q),
        .fill_line  (DDRAM_DOUT),
        .patch      ((state == WR) && !DDRAM_BUSY && cache_hit),
        .patch_lane (lane_q),
        .patch_byte (DDRAM_DIN[7:0])
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_line = '0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = we ? WR : (cache_hit ? HIT : RD);
            HIT:  state_nx = IDLE;
            RD:   if (!DDRAM_BUSY) state_nx = RDW;
            RDW:  if (DDRAM_DOUT_READY) state_nx = IDLE;
            WR:   if (!DDRAM_BUSY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        DDRAM_RD       = (state == RD);
        DDRAM_WE       = (state == WR);
        DDRAM_BURSTCNT = 8'd1;
        ready          = ready_r && !drain;
    end

    // Tracks a read the DDR has accepted but not yet answered. Deliberately
    // outside reset so a reset mid-read still swallows the late data beat;
    // relies on the FPGA register power-up value of 0.
    always_ff @(posedge clk_sys) begin
        if ((state == RD) && !DDRAM_BUSY)
            drain <= 1'b1;
        else if (DDRAM_DOUT_READY)
            drain <= 1'b0;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ready_r    <= 1'b1;
            dout       <= 8'hFF;
            DDRAM_ADDR <= DDR_BASE;
            DDRAM_DIN  <= '0;
            DDRAM_BE   <= '0;
            lane_q     <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            if ((state == IDLE) && !drain) begin
                req_q  <= rd | we;
                addr_q <= addr;
            end
            if (start) begin
                ready_r    <= 1'b0;
                DDRAM_ADDR <= DDR_BASE + 29'(addr[ADDR_W-1:3]);
                DDRAM_DIN  <= {8{din}};
                DDRAM_BE   <= lane_be(addr[2:0]);
                lane_q     <= addr[2:0];
            end
            case (state)
                HIT: begin
                    dout    <= cache_line[{lane_q, 3'b000} +: 8];
                    ready_r <= 1'b1;
                end
                RDW: if (DDRAM_DOUT_READY) begin
                    dout    <= DDRAM_DOUT[{lane_q, 3'b000} +: 8];
                    ready_r <= 1'b1;
                end
                WR: if (!DDRAM_BUSY) ready_r <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Directed plus randomized bench for gs_ddram_bridge against a DDR memory
// model with byte writes and an abstract "last line read" cache model.
module tb_gs_ddram_bridge;

    localparam logic [28:0] BASE = 29'h0600000;

    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd, we, ready;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    always #5 clk = ~clk;

    gs_ddram_bridge dut (
        .clk_sys          (clk),
        .reset            (reset),
        .addr             (addr),
        .din              (din),
        .dout             (dout),
        .rd               (rd),
        .we               (we),
        .ready            (ready),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE),
        .DDRAM_WE         (DDRAM_WE)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] mem [logic [28:0]];
    bit          c_valid = 1'b0;
    logic [28:0] c_word  = '0;
    logic [7:0]  last_rd = 8'hFF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_get(input logic [28:0] w);
        if (!mem.exists(w)) mem[w] = {$urandom, $urandom};
        return mem[w];
    endfunction

    function automatic bit model_hit(input logic [28:0] w);
`ifdef GS_BRIDGE_CACHE_EN
        return c_valid && (c_word == w);
`else
        return 1'b0;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_read(input logic [20:0] a, input int busy_n, input int lat);
        logic [28:0] w, rd_addr;
        logic [63:0] line;
        logic [7:0]  exp_b;
        bit          exp_hit, done, seen, stable;
        int          k, n_acc, cd, busy_left;
        w       = BASE + 29'(a[20:3]);
        line    = mem_get(w);
        exp_b   = line[a[2:0]*8 +: 8];
        exp_hit = model_hit(w);
        addr = a; rd = 1'b1; we = 1'b0;
        k = 0; n_acc = 0; cd = 0; done = 0; seen = 0; stable = 1; busy_left = busy_n;
        rd_addr = '0;
        while (!done && k < 60) begin
            cycle();
            k++;
            DDRAM_DOUT_READY = 1'b0;
            DDRAM_DOUT       = {$urandom, $urandom};
            DDRAM_BUSY       = 1'b0;
            if (ready) begin
                done = 1;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        DDRAM_DOUT_READY = 1'b1;
                        DDRAM_DOUT       = line;
                    end
                end
                if (DDRAM_RD) begin
                    if (!seen) begin
                        rd_addr = DDRAM_ADDR;
                        seen    = 1;
                    end else if (DDRAM_ADDR !== rd_addr) begin
                        stable = 0;
                    end
                    if (busy_left > 0) begin
                        DDRAM_BUSY = 1'b1;
                        busy_left--;
                    end else begin
                        n_acc++;
                        cd = lat;
                    end
                end
            end
        end
        rd = 1'b0;
        chk("rd_done", 64'(done), 64'd1);
        chk("rd_dout", 64'(dout), 64'(exp_b));
        chk("rd_cmds", 64'(n_acc), exp_hit ? 64'd0 : 64'd1);
        chk("rd_stable", 64'(stable), 64'd1);
        if (exp_hit) chk("hit_latency", 64'(k), 64'd2);
        else         chk("rd_addr", 64'(rd_addr), 64'(w));
        if (!exp_hit) begin
            c_valid = 1'b1;
            c_word  = w;
        end
        last_rd = exp_b;
        cycle();
    endtask

    task automatic do_write(input logic [20:0] a, input logic [7:0] d, input int busy_n, input bit both);
        logic [28:0] w, wa;
        logic [63:0] line, wdin;
        logic [7:0]  wbe;
        bit          done, seen, stable;
        int          k, n_acc, n_rd, busy_left;
        w = BASE + 29'(a[20:3]);
        addr = a; din = d; we = 1'b1; rd = both;
        k = 0; n_acc = 0; n_rd = 0; done = 0; seen = 0; stable = 1; busy_left = busy_n;
        wa = '0; wdin = '0; wbe = '0;
        while (!done && k < 60) begin
            cycle();
            k++;
            DDRAM_DOUT_READY = 1'b0;
            DDRAM_BUSY       = 1'b0;
            if (ready) begin
                done = 1;
            end else begin
                if (DDRAM_RD) n_rd++;
                if (DDRAM_WE) begin
                    if (!seen) begin
                        wa = DDRAM_ADDR; wdin = DDRAM_DIN; wbe = DDRAM_BE;
                        seen = 1;
                    end else if (DDRAM_ADDR !== wa || DDRAM_DIN !== wdin || DDRAM_BE !== wbe) begin
                        stable = 0;
                    end
                    if (busy_left > 0) begin
                        DDRAM_BUSY = 1'b1;
                        busy_left--;
                    end else begin
                        n_acc++;
                    end
                end
            end
        end
        we = 1'b0; rd = 1'b0;
        chk("wr_done", 64'(done), 64'd1);
        chk("wr_cmds", 64'(n_acc), 64'd1);
        chk("wr_no_rd", 64'(n_rd), 64'd0);
        chk("wr_stable", 64'(stable), 64'd1);
        chk("wr_addr", 64'(wa), 64'(w));
        chk("wr_din", wdin, {8{d}});
        chk("wr_be", 64'(wbe), 64'(8'd1 << a[2:0]));
        line = mem_get(w);
        line[a[2:0]*8 +: 8] = d;
        mem[w] = line;
        cycle();
    endtask

    initial begin
        logic [20:0] a;
        logic [28:0] w;
        reset = 1'b1; addr = '0; din = '0; rd = 1'b0; we = 1'b0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_dout", 64'(dout), 64'hFF);
        chk("rst_rd", 64'(DDRAM_RD), 64'd0);
        chk("rst_we", 64'(DDRAM_WE), 64'd0);
        chk("rst_be", 64'(DDRAM_BE), 64'd0);
        chk("rst_addr", 64'(DDRAM_ADDR), 64'(BASE));
        chk("rst_din", DDRAM_DIN, 64'd0);
        chk("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);

        // Miss then same-line read, then byte write and read-back
        mem[29'h0600002] = 64'h8877665544332211;
        do_read(21'h00010, 0, 3);
        do_read(21'h00013, 0, 1);
        do_write(21'h00015, 8'hA5, 0, 1'b0);
        do_read(21'h00015, 0, 2);

        // Busy stall on the read command
        do_read(21'h00200, 5, 2);

        // Reset one cycle after read acceptance; late beat must be swallowed
        a = 21'h00100;
        w = BASE + 29'(a[20:3]);
        mem[w] = 64'h0123456789ABCDEF;
        addr = a; rd = 1'b1;
        cycle();
        chk("mid_rd_issued", 64'(DDRAM_RD), 64'd1);
        cycle();
        reset = 1'b1; rd = 1'b0;
        cycle();
        reset = 1'b0;
        c_valid = 1'b0;
        chk("mid_rst_dout", 64'(dout), 64'hFF);
        chk("mid_rst_addr", 64'(DDRAM_ADDR), 64'(BASE));
        for (int i = 0; i < 3; i++) begin
            chk("drain_ready", 64'(ready), 64'd0);
            cycle();
        end
        DDRAM_DOUT = 64'hDEADBEEFCAFEF00D; DDRAM_DOUT_READY = 1'b1;
        cycle();
        DDRAM_DOUT_READY = 1'b0;
        chk("drain_done_ready", 64'(ready), 64'd1);
        chk("drain_dout", 64'(dout), 64'hFF);
        do_read(a, 0, 2);

        // Stray data beat while idle must be ignored
        DDRAM_DOUT = {$urandom, $urandom}; DDRAM_DOUT_READY = 1'b1;
        cycle();
        DDRAM_DOUT_READY = 1'b0;
        chk("stray_ready", 64'(ready), 64'd1);
        chk("stray_dout", 64'(dout), 64'(last_rd));

        // rd and we together at the top of the GS space: write wins
        do_write(21'h1FFFFF, 8'h5C, 2, 1'b1);

        // Randomized mix over a few hot lines plus occasional far addresses
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 4) == 0) ? 21'($urandom) : 21'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0)
                do_write(a, 8'($urandom), $urandom_range(0, 3), 1'($urandom));
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
